mrd_p4_pack: RTL

- Front-end packer for the Mixed Radix DFT datapath.
- Accepts a serial, one-sample-per-clock complex stream with packet framing.
- Emits the 4-parallel streaming format (sop/eop/valid, 4 lanes) consumed by the DFT memory top's sink stage.
- Gates packet starts on the memory top's sink_ready and repairs malformed packets so the DFT never sees a length mismatch.

---
 rtl/mrd_p4_pack.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mrd_p4_pack.sv
// Serial-to-4-lane packer feeding the Mixed Radix DFT sink stage.
// Frames packets, gates packet starts on sink_ready, and pads or truncates bad lengths.
module mrd_p4_pack #(
  parameter int wD      = 18,
  parameter int MAX_PTS = 1200,
  parameter int MIN_PTS = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_sop,
  input  logic            in_eop,
  input  logic [wD-1:0]   in_real,
  input  logic [wD-1:0]   in_imag,
  input  logic [11:0]     in_dftpts,
  input  logic [5:0]      in_size,
  output logic            in_ready,
  input  logic            sink_ready,
  output logic            out_valid,
  output logic            out_sop,
  output logic            out_eop,
  output logic [4*wD-1:0] out_real,
  output logic [4*wD-1:0] out_imag,
  output logic [11:0]     out_dftpts,
  output logic [5:0]      out_size,
  output logic            err_short,
  output logic            err_long,
  output logic            err_len
);

  // Handshake: a sample moves when in_valid && in_ready on a rising edge; the
  // output side has no backpressure, so every out_valid cycle is a delivered beat.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PAD  = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t          state;
  logic [11:0]     count;
  logic [3*wD-1:0] lane_re;
  logic [3*wD-1:0] lane_im;

  logic            accept;
  logic            pts_legal;
  logic [1:0]      lane;
  logic [11:0]     count_inc;
  logic [11:0]     count_up;
  logic [11:0]     count_pad;
  logic [4*wD-1:0] beat_re;
  logic [4*wD-1:0] beat_im;

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:       in_ready = sink_ready;
        FILL, DROP: in_ready = 1'b1;
        default:    in_ready = 1'b0;
      endcase
    end
  end

  assign accept    = in_valid && in_ready;
  assign lane      = count[1:0];
  assign count_inc = count + 12'd1;
  assign count_pad = count + 12'd4;
  assign pts_legal = (in_dftpts[1:0] == 2'b00) &&
                     (in_dftpts >= 12'(MIN_PTS)) &&
                     (in_dftpts <= 12'(MAX_PTS));

  // Sample count rounded up to the end of the beat the current sample closes.
  assign count_up = (count_inc[1:0] == 2'b00) ? count_inc
                                              : {count_inc[11:2] + 10'd1, 2'b00};

  // Beat closed by the incoming sample: buffered lower lanes, the new sample,
  // zeros above it. A normal lane-3 write simply has no zero lanes.
  always_comb begin
    beat_re = '0;
    beat_im = '0;
    for (int j = 0; j < 3; j++) begin
      if (2'(j) < lane) begin
        beat_re[j*wD +: wD] = lane_re[j*wD +: wD];
        beat_im[j*wD +: wD] = lane_im[j*wD +: wD];
      end
    end
    beat_re[int'(lane)*wD +: wD] = in_real;
    beat_im[int'(lane)*wD +: wD] = in_imag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      lane_re    <= '0;
      lane_im    <= '0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_real   <= '0;
      out_imag   <= '0;
      out_dftpts <= '0;
      out_size   <= '0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      err_len   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && in_sop) begin
            out_dftpts <= in_dftpts;
            out_size   <= in_size;
            if (!pts_legal) begin
              err_len <= 1'b1;
              state   <= in_eop ? IDLE : DROP;
            end else if (in_eop) begin
              // A one-sample packet is repaired like any other short packet.
              out_valid <= 1'b1;
              out_sop   <= 1'b1;
              out_real  <= beat_re;
              out_imag  <= beat_im;
              err_short <= 1'b1;
              count     <= 12'd4;
              state     <= PAD;
            end else begin
              lane_re[wD-1:0] <= in_real;
              lane_im[wD-1:0] <= in_imag;
              count           <= 12'd1;
              state           <= FILL;
            end
          end
        end

        FILL: begin
          if (accept) begin
            if (lane != 2'd3) begin
              lane_re[int'(lane)*wD +: wD] <= in_real;
              lane_im[int'(lane)*wD +: wD] <= in_imag;
            end
            count <= count_inc;
            if (count_inc == out_dftpts) begin
              out_valid <= 1'b1;
              out_sop   <= (count_inc == 12'd4);
              out_eop   <= 1'b1;
              out_real  <= beat_re;
              out_imag  <= beat_im;
              count     <= '0;
              if (in_eop) begin
                state <= IDLE;
              end else begin
                err_long <= 1'b1;
                state    <= DROP;
              end
            end else if (in_eop) begin
              out_valid <= 1'b1;
              out_sop   <= (count_up == 12'd4);
              out_real  <= beat_re;
              out_imag  <= beat_im;
              err_short <= 1'b1;
              if (count_up == out_dftpts) begin
                out_eop <= 1'b1;
                count   <= '0;
                state   <= IDLE;
              end else begin
                count <= count_up;
                state <= PAD;
              end
            end else if (lane == 2'd3) begin
              out_valid <= 1'b1;
              out_sop   <= (count_inc == 12'd4);
              out_real  <= beat_re;
              out_imag  <= beat_im;
            end
          end
        end

        PAD: begin
          out_valid <= 1'b1;
          out_real  <= '0;
          out_imag  <= '0;
          if (count_pad == out_dftpts) begin
            out_eop <= 1'b1;
            count   <= '0;
            state   <= IDLE;
          end else begin
            count <= count_pad;
          end
        end

        DROP: begin
          if (accept && in_eop) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
